// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: single-outstanding load/store stage between the execute ALU and the data-cache bus
module lsu_mem_stage #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ex_valid,
   input  logic              mem_rd,
   input  logic              mem_wr,
   input  logic [1:0]        mem_size,
   input  logic              mem_unsigned,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              flush,
   output logic              d_req,
   output logic              d_we,
   output logic [ADDR_W-1:0] d_addr,
   output logic [DATA_W-1:0] d_wdata,
   output logic [7:0]        d_wstrb,
   input  logic              d_ready,
   input  logic              d_resp_valid,
   input  logic [DATA_W-1:0] d_rdata,
   output logic              lsu_stall,
   output logic              res_valid,
   output logic [DATA_W-1:0] res_o,
   output logic              ld_misalign,
   output logic              st_misalign
);
   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;
   state_e state_q, state_d;
   logic killed_q, killed_d, we_q, we_d, uns_q, uns_d;
   logic [1:0] size_q, size_d;
   logic [2:0] off_q, off_d;
   logic [7:0] wstrb_q, wstrb_d, mask;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d, res_q, res_d, sh, ext;
   logic op, mis, start;
   assign op = ex_valid & (mem_rd | mem_wr);
   assign mis = (mem_size == 2'd1 & addr_i[0]) | (mem_size == 2'd2 & |addr_i[1:0]) | (mem_size == 2'd3 & |addr_i[2:0]);
   assign start = state_q == IDLE & op & ~mis & ~flush;
   assign mask = mem_size == 2'd0 ? 8'h01 : mem_size == 2'd1 ? 8'h03 : mem_size == 2'd2 ? 8'h0F : 8'hFF;
   assign sh = d_rdata >> {off_q, 3'b000};
   assign ext = we_q ? '0 :
                size_q == 2'd0 ? {{(DATA_W-8){sh[7] & ~uns_q}}, sh[7:0]} :
                size_q == 2'd1 ? {{(DATA_W-16){sh[15] & ~uns_q}}, sh[15:0]} :
                size_q == 2'd2 ? {{(DATA_W-32){sh[31] & ~uns_q}}, sh[31:0]} : sh;
   always_comb begin
      state_d  = state_q;
      killed_d = killed_q;
      we_d     = we_q;
      uns_d    = uns_q;
      size_d   = size_q;
      off_d    = off_q;
      wstrb_d  = wstrb_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      res_d    = res_q;
      case (state_q)
         IDLE: if (start) begin
            state_d = REQ;
            addr_d  = {addr_i[ADDR_W-1:3], 3'b000};
            we_d    = mem_wr;
            wstrb_d = mask << addr_i[2:0];
            wdata_d = wdata_i << {addr_i[2:0], 3'b000};
            size_d  = mem_size;
            uns_d   = mem_unsigned;
            off_d   = addr_i[2:0];
         end
         REQ: begin
            killed_d = killed_q | flush;
            if (d_ready) state_d = WAIT;
         end
         WAIT: begin
            killed_d = killed_q | flush;
            if (d_resp_valid) begin
               state_d = DONE;
               res_d   = killed_d ? res_q : ext;
            end
         end
         DONE: begin
            state_d  = IDLE;
            killed_d = 1'b0;
         end
      endcase
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         killed_q <= 1'b0;
         we_q     <= 1'b0;
         uns_q    <= 1'b0;
         size_q   <= '0;
         off_q    <= '0;
         wstrb_q  <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         res_q    <= '0;
      end else begin
         state_q  <= state_d;
         killed_q <= killed_d;
         we_q     <= we_d;
         uns_q    <= uns_d;
         size_q   <= size_d;
         off_q    <= off_d;
         wstrb_q  <= wstrb_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         res_q    <= res_d;
      end
   end
   assign d_req     = state_q == REQ;
   assign d_we      = we_q;
   assign d_addr    = addr_q;
   assign d_wdata   = wdata_q;
   assign d_wstrb   = wstrb_q;
   assign res_o     = res_q;
   assign res_valid = state_q == DONE & ~killed_q & ~flush;
   // the pipeline advances in DONE; a killed op only stalls whatever the execute stage now holds
   assign lsu_stall = rst & (state_q == DONE ? killed_q & op : state_q != IDLE | (op & ~mis & ~flush));
   assign ld_misalign = rst & state_q == IDLE & op & mis & ~flush & mem_rd;
   assign st_misalign = rst & state_q == IDLE & op & mis & ~flush & mem_wr;
endmodule

// File: tb/tb_lsu_mem_stage.sv
// tb_lsu_mem_stage: randomized and directed checks of lsu_mem_stage against a byte-level reference model
module tb_lsu_mem_stage;
   logic clk, rst, ex_valid, mem_rd, mem_wr, mem_unsigned, flush;
   logic [1:0] mem_size;
   logic [63:0] addr_i, wdata_i, d_addr, d_wdata, d_rdata, res_o;
   logic d_req, d_we, d_ready, d_resp_valid, lsu_stall, res_valid, ld_misalign, st_misalign;
   logic [7:0] d_wstrb;
   int checks = 0, errors = 0;

   lsu_mem_stage #(.ADDR_W(64), .DATA_W(64)) dut (
      .clk(clk), .rst(rst), .ex_valid(ex_valid), .mem_rd(mem_rd), .mem_wr(mem_wr),
      .mem_size(mem_size), .mem_unsigned(mem_unsigned), .addr_i(addr_i), .wdata_i(wdata_i),
      .flush(flush), .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_wstrb(d_wstrb), .d_ready(d_ready), .d_resp_valid(d_resp_valid), .d_rdata(d_rdata),
      .lsu_stall(lsu_stall), .res_valid(res_valid), .res_o(res_o),
      .ld_misalign(ld_misalign), .st_misalign(st_misalign)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] strb_m(input logic [1:0] sz, input logic [2:0] off);
      logic [7:0] s;
      int o;
      s = '0;
      o = int'(off);
      for (int i = 0; i < (1 << sz); i++) s[o + i] = 1'b1;
      return s;
   endfunction

   function automatic logic [63:0] wdata_m(input logic [63:0] wd, input logic [2:0] off);
      logic [63:0] r;
      int o;
      r = '0;
      o = int'(off);
      for (int i = 0; i < 8 - o; i++) r[8*(o+i) +: 8] = wd[8*i +: 8];
      return r;
   endfunction

   function automatic logic [63:0] load_m(input logic [63:0] rd, input logic [2:0] off, input logic [1:0] sz, input logic uns);
      logic [63:0] v;
      int n, o;
      v = '0;
      n = 1 << sz;
      o = int'(off);
      for (int i = 0; i < n; i++) v[8*i +: 8] = rd[8*(o+i) +: 8];
      if (!uns && v[8*n-1]) for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
      return v;
   endfunction

   task automatic idle_inputs();
      ex_valid = 0; mem_rd = 0; mem_wr = 0; mem_size = 0; mem_unsigned = 0; flush = 0;
      addr_i = '0; wdata_i = '0; d_ready = 0; d_resp_valid = 0; d_rdata = '0;
   endtask

   task automatic run_op(input logic wr, input logic [1:0] sz, input logic uns, input logic [63:0] a,
                         input logic [63:0] wd, input logic [63:0] rd, input int rdy_wait,
                         input int resp_wait, input logic do_flush);
      logic [63:0] exp_res, exp_addr, exp_wd;
      logic [7:0] exp_strb;
      exp_res  = wr ? 64'd0 : load_m(rd, a[2:0], sz, uns);
      exp_addr = {a[63:3], 3'b000};
      exp_wd   = wdata_m(wd, a[2:0]);
      exp_strb = strb_m(sz, a[2:0]);
      @(negedge clk);
      ex_valid = 1; mem_rd = ~wr; mem_wr = wr; mem_size = sz; mem_unsigned = uns; addr_i = a;
      wdata_i = wd; d_rdata = rd; d_ready = 0; d_resp_valid = 0; flush = 0;
      #1;
      checks++;
      if (lsu_stall !== 1'b1 || d_req !== 1'b0 || ld_misalign !== 1'b0 || st_misalign !== 1'b0) begin
         errors++;
         $display("FAIL issue stall=%b req=%b ldm=%b stm=%b expected 1 0 0 0", lsu_stall, d_req, ld_misalign, st_misalign);
      end
      for (int k = 0; k <= rdy_wait; k++) begin
         @(negedge clk);
         #1;
         checks++;
         if (d_req !== 1'b1 || d_we !== wr || lsu_stall !== 1'b1 || d_addr !== exp_addr ||
             d_wstrb !== exp_strb || d_wdata !== exp_wd) begin
            errors++;
            $display("FAIL req_phase cyc=%0d req=%b we=%b stall=%b addr=%h strb=%h wdata=%h expected 1 %b 1 %h %h %h",
                     k, d_req, d_we, lsu_stall, d_addr, d_wstrb, d_wdata, wr, exp_addr, exp_strb, exp_wd);
         end
         d_ready = (k == rdy_wait);
      end
      for (int k = 0; k <= resp_wait; k++) begin
         @(negedge clk);
         d_ready = 0;
         #1;
         checks++;
         if (d_req !== 1'b0 || lsu_stall !== 1'b1 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL wait_phase cyc=%0d req=%b stall=%b res_valid=%b expected 0 1 0", k, d_req, lsu_stall, res_valid);
         end
         flush = do_flush && k == 0;
         d_resp_valid = (k == resp_wait);
      end
      @(negedge clk);
      d_resp_valid = 0;
      flush = 0;
      #1;
      checks++;
      if (res_valid !== ~do_flush || lsu_stall !== do_flush || d_req !== 1'b0 || (!do_flush && res_o !== exp_res)) begin
         errors++;
         $display("FAIL done res_valid=%b stall=%b req=%b res=%h expected %b %b 0 %h",
                  res_valid, lsu_stall, d_req, res_o, ~do_flush, do_flush, exp_res);
      end
      ex_valid = 0; mem_rd = 0; mem_wr = 0;
      @(negedge clk);
      #1;
      checks++;
      if (res_valid !== 1'b0 || d_req !== 1'b0 || lsu_stall !== 1'b0) begin
         errors++;
         $display("FAIL back_idle res_valid=%b req=%b stall=%b expected 0 0 0", res_valid, d_req, lsu_stall);
      end
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 0;
      #1;
      checks++;
      if ({d_req, d_we, d_addr, d_wdata, d_wstrb, lsu_stall, res_valid, res_o, ld_misalign, st_misalign} !== '0) begin
         errors++;
         $display("FAIL reset req=%b we=%b addr=%h wdata=%h strb=%h stall=%b rv=%b res=%h expected all 0",
                  d_req, d_we, d_addr, d_wdata, d_wstrb, lsu_stall, res_valid, res_o);
      end
      repeat (2) @(negedge clk);
      rst = 1;
   endtask

   task automatic test_load_byte();
      run_op(0, 2'd0, 0, 64'h1003, 64'h0, 64'h0000_0000_80FF_0000, 0, 0, 0);
      run_op(0, 2'd0, 1, 64'h1003, 64'h0, 64'h0000_0000_80FF_0000, 0, 0, 0);
   endtask

   task automatic test_store_word();
      run_op(1, 2'd2, 0, 64'h2004, 64'h1122_3344, 64'hDEAD_BEEF_DEAD_BEEF, 1, 2, 0);
   endtask

   task automatic test_misalign();
      @(negedge clk);
      ex_valid = 1; mem_rd = 1; mem_wr = 0; mem_size = 2'd2; addr_i = 64'h3002;
      d_ready = 1; d_resp_valid = 1;
      for (int k = 0; k < 2; k++) begin
         #1;
         checks++;
         if (ld_misalign !== 1'b1 || st_misalign !== 1'b0 || lsu_stall !== 1'b0 || d_req !== 1'b0 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL ld_misalign cyc=%0d ldm=%b stm=%b stall=%b req=%b rv=%b expected 1 0 0 0 0",
                     k, ld_misalign, st_misalign, lsu_stall, d_req, res_valid);
         end
         @(negedge clk);
      end
      mem_rd = 0; mem_wr = 1; mem_size = 2'd3; addr_i = 64'h3004;
      #1;
      checks++;
      if (st_misalign !== 1'b1 || ld_misalign !== 1'b0 || lsu_stall !== 1'b0 || d_req !== 1'b0) begin
         errors++;
         $display("FAIL st_misalign stm=%b ldm=%b stall=%b req=%b expected 1 0 0 0", st_misalign, ld_misalign, lsu_stall, d_req);
      end
      flush = 1;
      #1;
      checks++;
      if (st_misalign !== 1'b0) begin
         errors++;
         $display("FAIL misalign_flush stm=%b expected 0", st_misalign);
      end
      @(negedge clk);
      idle_inputs();
   endtask

   task automatic test_backpressure();
      run_op(0, 2'd3, 0, 64'hABCD_0000_0000_5A58, 64'h0, 64'h8877_6655_4433_2211, 5, 1, 0);
   endtask

   task automatic test_flush_wait();
      run_op(0, 2'd3, 0, 64'h4000, 64'h0, 64'hFFFF_0000_1234_5678, 0, 3, 1);
      run_op(0, 2'd1, 0, 64'h4006, 64'h0, 64'h8001_0000_0000_0000, 0, 0, 0);
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      ex_valid = 1; mem_rd = 1; mem_wr = 0; mem_size = 2'd3; addr_i = 64'h48; d_ready = 1;
      @(negedge clk);
      @(negedge clk);
      d_ready = 0;
      #1;
      checks++;
      if (d_addr !== 64'h48 || lsu_stall !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset addr=%h stall=%b expected 48 1", d_addr, lsu_stall);
      end
      #1;
      ex_valid = 0; mem_rd = 0;
      rst = 0;
      #1;
      checks++;
      if ({d_req, d_we, d_addr, d_wdata, d_wstrb, lsu_stall, res_valid, res_o, ld_misalign, st_misalign} !== '0) begin
         errors++;
         $display("FAIL async_reset req=%b addr=%h stall=%b rv=%b expected all 0", d_req, d_addr, lsu_stall, res_valid);
      end
      @(negedge clk);
      rst = 1;
      run_op(0, 2'd3, 0, 64'h0, 64'h0, 64'h0123_4567_89AB_CDEF, 0, 0, 0);
   endtask

   task automatic test_random();
      logic [1:0] sz;
      logic [63:0] a;
      for (int n = 0; n < 40; n++) begin
         sz = 2'($urandom_range(3));
         a = {$urandom(), $urandom()} & ~((64'd1 << sz) - 64'd1);
         run_op(1'($urandom_range(1)), sz, 1'($urandom_range(1)), a, {$urandom(), $urandom()},
                {$urandom(), $urandom()}, $urandom_range(3), $urandom_range(3), $urandom_range(7) == 0);
      end
   endtask

   initial begin
      test_reset();
      test_load_byte();
      test_store_word();
      test_misalign();
      test_backpressure();
      test_flush_wait();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
- Memory-access stage directly downstream of the execute ALU.
- Takes the ALU result as effective address, plus store data and memory-op controls, and runs a single outstanding load/store on the data-cache request/response bus.
- Aligns, strobes and sign/zero-extends data, detects misalignment, and stalls the pipeline until the access completes.

Parameters:
ADDR_W, 64, effective address width
DATA_W, 64, data bus width (only 64 is supported; 8 byte lanes)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
ex_valid  in  1  execute stage holds a valid instruction
mem_rd  in  1  instruction is a load
mem_wr  in  1  instruction is a store (mem_rd and mem_wr are never both set)
mem_size  in  2  0=byte, 1=half, 2=word, 3=double
mem_unsigned  in  1  zero-extend load result
addr_i  in  ADDR_W  effective address (ALU res_o)
wdata_i  in  DATA_W  store data (rs2), right-aligned
flush  in  1  kill the current instruction (exception/redirect)
d_req  out  1  bus request valid
d_we  out  1  request is a write
d_addr  out  ADDR_W  request address, low 3 bits forced to 0
d_wdata  out  DATA_W  store data shifted to its byte lane
d_wstrb  out  8  byte-enable
d_ready  in  1  bus accepts the request this cycle
d_resp_valid  in  1  response/ack valid
d_rdata  in  DATA_W  read data, 64-bit aligned
lsu_stall  out  1  hold the pipeline
res_valid  out  1  load result / store completion valid
res_o  out  DATA_W  extended load data (0 for stores)
ld_misalign  out  1  load address misaligned
st_misalign  out  1  store address misaligned

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, killed=0, and every output is 0.
- op = ex_valid & (mem_rd|mem_wr).
- mis = (size1 & addr[0]) | (size2 & |addr[1:0]) | (size3 & |addr[2:0]).
- Misaligned op, in IDLE, combinational:
  - ld_misalign/st_misalign = op & mis & ~flush, with type selected by mem_rd/mem_wr.
  - No bus request, no stall.
- State machine IDLE -> REQ -> WAIT -> DONE -> IDLE.
- IDLE: op & ~mis & ~flush, at the clock edge:
  - Register d_addr = {addr[63:3],3'b0} and d_we = mem_wr.
  - d_wstrb = size mask (0x01/0x03/0x0F/0xFF) << addr[2:0].
  - d_wdata = wdata_i << (8*addr[2:0]).
  - Register the size, unsigned flag and offset.
  - Go to REQ.
- REQ: d_req=1; all d_* outputs held stable until d_ready. On d_ready go to WAIT. Entering REQ to first d_req = 1 cycle.
- WAIT: d_req=0. On d_resp_valid go to DONE, capturing the extended result.
  - Load result: shift d_rdata right by 8*offset, take the low 8/16/32/64 bits, sign-extend unless unsigned.
  - Store result: 0.
- DONE: res_valid=1 for exactly one cycle when killed=0, then IDLE, clearing killed.
- lsu_stall:
  - (op & ~mis & ~flush & state!=DONE) | (state!=IDLE & state!=DONE).
  - In DONE with killed=1: stall = op.
  - The pipeline advances in the DONE cycle.
- Minimum load/store latency with d_ready and d_resp_valid asserted on first opportunity: 4 cycles IDLE->DONE; the stall covers 3 cycles.
- flush in REQ or WAIT: an accepted or pending request is never withdrawn. Set killed=1, complete the bus handshake, discard the data; res_valid stays 0.
- flush in IDLE: no op is started.
- flush in DONE: res_valid is suppressed.
- d_resp_valid outside WAIT: ignored (protocol error, no state change).
- d_ready outside REQ: ignored.
- Reset mid-transaction: immediate return to IDLE; the bus side must also be reset.
- Width rules: all shifts use offset addr[2:0] only; the upper address bits never affect lane selection.

Test Plan:
- Aligned load: LB addr=0x1003, d_rdata=0x0000_0000_80FF_0000 -> d_addr=0x1000, res_o=0xFFFF_FFFF_FFFF_FF80, res_valid 1 cycle; LBU gives 0x80.
- Store word: SW addr=0x2004, wdata=0x1122_3344 -> d_we=1, d_wstrb=0xF0, d_wdata=0x1122_3344_0000_0000, stall until ack, res_o=0.
- Misaligned: LW addr=0x3002 -> ld_misalign=1 same cycle, d_req never asserted, lsu_stall=0; SD addr=0x3004 -> st_misalign=1.
- Backpressure: d_ready held low 5 cycles in REQ -> d_addr/d_wdata/d_wstrb stable throughout, lsu_stall high, single transaction.
- Flush mid-WAIT: LD pending, flush=1 -> transaction still completes on d_resp_valid; res_valid never asserted; next op starts only after DONE.
- Async reset: rst low during WAIT -> all outputs 0 immediately; after release, a new LD addr=0x0 completes with latency 4.
